trace_misr: RTL

TRACE_MISR -- requirements
Module: trace_misr

---
 rtl/trace_misr_pkg.sv | 14 +
 rtl/misr_fold.sv | 37 +++
 rtl/trace_misr.sv | 92 +++++++++
 3 files changed

// File: rtl/trace_misr_pkg.sv
// Shared definitions for the trace MISR: FSM state encoding and default
// feedback polynomial / seed constants.
package trace_misr_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'hFFFFFFFF;

endpackage

// File: rtl/misr_fold.sv
// Combinational next-signature: shift with polynomial feedback, XORed with the
// fold of all valid channels (channel c rotated left by 8*c bits).
module misr_fold
  import trace_misr_pkg::*;
#(
  parameter int unsigned     SIG_W  = 32,
  parameter int unsigned     CH     = 3,
  parameter int unsigned     DATA_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY)
) (
  input  logic [SIG_W-1:0]     i_sig,
  input  logic [CH-1:0]        i_valid,
  input  logic [CH*DATA_W-1:0] i_data,
  output logic [SIG_W-1:0]     o_sig_nxt
);

  function automatic logic [SIG_W-1:0] rotl(input logic [SIG_W-1:0] x, input int unsigned sh);
    // sh == 0 is safe: a shift by the full width yields zero.
    return (x << sh) | (x >> (SIG_W - sh));
  endfunction

  logic [SIG_W-1:0] w_fold;
  logic [SIG_W-1:0] w_ext;

  always_comb begin
    w_fold = '0;
    w_ext  = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      w_ext = SIG_W'(i_data[c*DATA_W +: DATA_W]);
      if (i_valid[c]) begin
        w_fold = w_fold ^ rotl(w_ext, (8 * c) % SIG_W);
      end
    end
    o_sig_nxt = {i_sig[SIG_W-2:0], 1'b0} ^ (i_sig[SIG_W-1] ? POLY : '0) ^ w_fold;
  end

endmodule

// File: rtl/trace_misr.sv
// Trace signature compactor: captures a window of window_len cycles of
// multi-channel trace data into a MISR signature.
module trace_misr
  import trace_misr_pkg::*;
#(
  parameter int unsigned      SIG_W  = 32,
  parameter int unsigned      CH     = 3,
  parameter int unsigned      DATA_W = 16,
  parameter int unsigned      CNT_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED)
) (
  input  logic                 clk,
  input  logic                 irst_done_reg,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     window_len,
  input  logic [CH-1:0]        ch_valid,
  input  logic [CH*DATA_W-1:0] ch_data,
  output logic [SIG_W-1:0]     sig,
  output logic                 sig_valid,
  output logic                 busy,
  output logic [CNT_W-1:0]     cycle_cnt
);

  state_e           r_state, w_state_nxt;
  logic [SIG_W-1:0] r_sig, w_sig_nxt, w_fold_sig;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [CNT_W-1:0] r_len, w_len_nxt;

  misr_fold #(
    .SIG_W  (SIG_W),
    .CH     (CH),
    .DATA_W (DATA_W),
    .POLY   (POLY)
  ) u_fold (
    .i_sig     (r_sig),
    .i_valid   (ch_valid),
    .i_data    (ch_data),
    .o_sig_nxt (w_fold_sig)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_sig_nxt   = r_sig;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    // Abort wins over both start and the terminal update; sig/count are kept.
    if (abort) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StRun: begin
          w_sig_nxt = w_fold_sig;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == r_len) w_state_nxt = StDone;
        end
        StIdle, StDone: begin
          if (start) begin
            w_sig_nxt   = SEED;
            w_cnt_nxt   = '0;
            w_len_nxt   = window_len;
            w_state_nxt = (window_len == '0) ? StDone : StRun;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge irst_done_reg) begin
    if (irst_done_reg) begin
      r_state <= StIdle;
      r_sig   <= SEED;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sig   <= w_sig_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
    end
  end

  assign sig       = r_sig;
  assign cycle_cnt = r_cnt;
  assign busy      = (r_state == StRun);
  assign sig_valid = (r_state == StDone);

endmodule
